if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/mips_pkg.sv | 36 +++
 rtl/pc_register.sv | 41 ++++
 rtl/if_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg -- shared constants and types for the instruction-fetch stage.
//
// Contents:
//   INSTR_W           instruction / address width (32)
//   NOP_INSTR         encoding inserted into IF/ID as a bubble
//   PC_INCR           byte distance between sequential instructions (4)
//   DEFAULT_RESET_PC  default address of the first fetch after reset
//   COUNT_MAX         saturation value of the delivered-instruction counter
//   fetch_action_e    the single action the fetch stage takes on an edge
//   align_pc()        forces a byte address onto a word boundary
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] PC_INCR          = 32'd4;
  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] COUNT_MAX        = 32'hFFFF_FFFF;

  // Exactly one of these applies per edge, listed from highest priority down.
  typedef enum logic [2:0] {
    ACT_REDIRECT = 3'd0,  // taken branch/jump: load target, bubble IF/ID
    ACT_FLUSH    = 3'd1,  // squash the word being captured, PC held
    ACT_HOLD     = 3'd2,  // hazard stall: everything frozen
    ACT_WAIT     = 3'd3,  // memory not ready: PC held, bubble IF/ID
    ACT_FETCH    = 3'd4   // capture word, advance PC
  } fetch_action_e;

  // Instructions are word aligned; the two low address bits are dropped.
  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_register.sv
// ----------------------------------------------------------------------------
// pc_register -- 32-bit program counter.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset, PC <= RESET_PC (word aligned)
//   load     load load_pc (aligned); has priority over advance
//   load_pc  target address for load
//   advance  PC <= PC + 4 (wraps modulo 2^32)
//   pc       current program counter
// With neither load nor advance asserted the PC holds.
// ----------------------------------------------------------------------------
module pc_register
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        advance,
  output logic [31:0] pc
);

  logic [31:0] pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= align_pc(RESET_PC);
    end else if (load) begin
      pc_reg <= align_pc(load_pc);
    end else if (advance) begin
      // 32-bit addition naturally wraps 0xFFFF_FFFC -> 0x0000_0000.
      pc_reg <= pc_reg + PC_INCR;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   stall              hold PC, IF/ID and fetch_count
//   flush              bubble IF/ID, PC held
//   redirect_valid/pc  load PC with the (aligned) target, bubble IF/ID
//   imem_addr          current PC (combinational)
//   imem_req           fetch request, high whenever not in reset
//   imem_rdata/ready   instruction word and its same-cycle handshake
//   ifid_instruction   captured instruction (NOP when bubble)
//   ifid_pc4           PC+4 of the captured instruction (0 when bubble)
//   ifid_valid         IF/ID holds a real instruction
//   fetch_count        saturating count of instructions delivered to IF/ID
// ----------------------------------------------------------------------------
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  fetch_action_e action;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;

  logic [31:0]   ifid_instruction_reg;
  logic [31:0]   ifid_pc4_reg;
  logic          ifid_valid_reg;
  logic [31:0]   fetch_count_reg;

  // Resolve the per-edge priority into one action so the PC and the IF/ID
  // register can never disagree about what happened on this edge.
  always_comb begin
    action = ACT_FETCH;
    if (redirect_valid) begin
      action = ACT_REDIRECT;
    end else if (flush) begin
      action = ACT_FLUSH;
    end else if (stall) begin
      action = ACT_HOLD;
    end else if (!imem_ready) begin
      action = ACT_WAIT;
    end
  end

  assign pc_plus4 = pc + PC_INCR;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .rst     (rst),
    .load    (action == ACT_REDIRECT),
    .load_pc (redirect_pc),
    .advance (action == ACT_FETCH),
    .pc      (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instruction_reg <= NOP_INSTR;
      ifid_pc4_reg         <= '0;
      ifid_valid_reg       <= 1'b0;
      fetch_count_reg      <= '0;
    end else begin
      case (action)
        ACT_FETCH: begin
          ifid_instruction_reg <= imem_rdata;
          ifid_pc4_reg         <= pc_plus4;
          ifid_valid_reg       <= 1'b1;
          if (fetch_count_reg != COUNT_MAX) begin
            fetch_count_reg <= fetch_count_reg + 32'd1;
          end
        end
        ACT_HOLD: begin
          // Everything keeps its value for the stalled edge.
        end
        default: begin
          // Redirect, flush and wait states all leave a bubble behind.
          ifid_instruction_reg <= NOP_INSTR;
          ifid_pc4_reg         <= '0;
          ifid_valid_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr        = pc;
  // Driven straight from rst so the request drops the moment reset asserts.
  assign imem_req         = ~rst;
  assign ifid_instruction = ifid_instruction_reg;
  assign ifid_pc4         = ifid_pc4_reg;
  assign ifid_valid       = ifid_valid_reg;
  assign fetch_count      = fetch_count_reg;

endmodule
